// File: rtl/instr_encoder_if.sv
// Request/instruction-memory bundle shared by the encoder and whoever drives it.
// Latency: none, wiring only.
// Backpressure: carries the in_valid/in_ready handshake; INSTR_ENCODER_CHECKSUM_EN adds checksum.
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op_sel;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              clear;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [31:0]       checksum;

  modport master (
    output in_valid, op_sel, rs, rt, rd, imm, target, clear,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, full, err, checksum
  );
  modport slave (
    input  in_valid, op_sel, rs, rt, rd, imm, target, clear,
    output in_ready, imem_we, imem_addr, imem_wdata, count, full, err, checksum
  );
`else
  modport master (
    output in_valid, op_sel, rs, rt, rd, imm, target, clear,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, full, err
  );
  modport slave (
    input  in_valid, op_sel, rs, rt, rd, imm, target, clear,
    output in_ready, imem_we, imem_addr, imem_wdata, count, full, err
  );
`endif
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder: packs R/I/J requests into 32-bit words and writes them to instruction memory.
// Latency: a legal request accepted on edge N is written (imem_we=1) in cycle N+1; one word per 2 cycles.
// Backpressure: in_ready low in the write cycle, when full, while clear is high and during reset.
// Optional feature macro: INSTR_ENCODER_CHECKSUM_EN adds a running XOR checksum of written words.
module instr_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   CAP_CNT  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);

  state_t            r_state;
  state_t            w_next;
  logic              r_live;     // low in reset, high from the first edge after release
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       w_word;
  logic              w_legal;
  logic              w_accept;
  logic              w_full;
  logic              w_ready;
  logic              w_we;
  logic [ADDR_W:0]   w_cnt_inc;

  assign w_legal   = (bus.op_sel <= 4'd9);
  assign w_full    = (r_cnt == CAP_CNT);
  assign w_accept  = bus.in_valid && w_ready;
  assign w_cnt_inc = r_cnt + CNT_ONE;

  // Field packing for each supported operation; illegal codes produce no word.
  always_comb begin
    w_word = 32'h0;
    case (bus.op_sel)
      4'd0:    w_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100000};
      4'd1:    w_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100010};
      4'd2:    w_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100100};
      4'd3:    w_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100101};
      4'd4:    w_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b101010};
      4'd5:    w_word = {6'b001000, bus.rs, bus.rt, bus.imm};
      4'd6:    w_word = {6'b100011, bus.rs, bus.rt, bus.imm};
      4'd7:    w_word = {6'b101011, bus.rs, bus.rt, bus.imm};
      4'd8:    w_word = {6'b000100, bus.rs, bus.rt, bus.imm};
      4'd9:    w_word = {6'b000010, bus.target};
      default: w_word = 32'h0;
    endcase
  end

  // State register; async reset also kills an in-flight write immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: clear wins everywhere, illegal accepts stay in IDLE.
  always_comb begin
    w_next = r_state;
    if (bus.clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept && w_legal) w_next = S_WRITE;
        S_WRITE: w_next = (w_cnt_inc == CAP_CNT) ? S_FULL : S_IDLE;
        S_FULL:  w_next = S_FULL;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Handshake and write strobe decoded from the current state.
  always_comb begin
    w_ready = r_live && (r_state == S_IDLE) && !w_full && !bus.clear;
    w_we    = (r_state == S_WRITE) && !bus.clear;
  end

  // Pointer, count, captured word/address and error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live  <= 1'b0;
      r_ptr   <= BASE_PTR;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_err  <= w_accept && !w_legal;
      if (bus.clear) begin
        r_ptr <= BASE_PTR;
        r_cnt <= '0;
      end else if (r_state == S_WRITE) begin
        r_ptr <= r_ptr + PTR_ONE;
        r_cnt <= w_cnt_inc;
      end
      // Accept only happens in IDLE without clear, so it never collides with the updates above.
      if (w_accept && w_legal) begin
        r_addr  <= r_ptr;
        r_wdata <= w_word;
      end
    end
  end

`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [31:0] r_csum;

  // Running XOR of every word that actually reaches memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum <= 32'h0;
    end else if (bus.clear) begin
      r_csum <= 32'h0;
    end else if (r_state == S_WRITE) begin
      r_csum <= r_csum ^ r_wdata;
    end
  end

  assign bus.checksum = r_csum;
`endif

  assign bus.in_ready   = w_ready;
  assign bus.imem_we    = w_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.count      = r_cnt;
  assign bus.full       = w_full;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two ADDR_W=2 instances (BASE_ADDR 0 and 3) share one stimulus stream.
// Expected values come from a transaction-level model (count, pending word) and a constant vector table.
module tb_instr_encoder;

  localparam int CAP = 4;
  localparam int B1  = 3;

  logic clk;
  logic rst;

  instr_encoder_if #(.ADDR_W(2)) if0 ();
  instr_encoder_if #(.ADDR_W(2)) if1 ();

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  instr_encoder #(.ADDR_W(2), .BASE_ADDR(B1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if1.in_valid = if0.in_valid;
  assign if1.op_sel   = if0.op_sel;
  assign if1.rs       = if0.rs;
  assign if1.rt       = if0.rt;
  assign if1.rd       = if0.rd;
  assign if1.imm      = if0.imm;
  assign if1.target   = if0.target;
  assign if1.clear    = if0.clear;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model
  bit          m_live, m_pend, m_err, m_acc;
  int          m_cnt, m_la0, m_la1;
  logic [31:0] m_lw, m_csum;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    bit          clr_before;
    logic [31:0] word;
    int          addr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_encode(input logic [3:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] f;
    logic [31:0] regs_r;
    logic [31:0] regs_i;
    regs_r = (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11);
    regs_i = (32'(rs) << 21) + (32'(rt) << 16) + 32'(imm);
    case (op)
      4'd0: f = 32;
      4'd1: f = 34;
      4'd2: f = 36;
      4'd3: f = 37;
      4'd4: f = 42;
      4'd5: f = 8;
      4'd6: f = 35;
      4'd7: f = 43;
      4'd8: f = 4;
      default: f = 2;
    endcase
    if (op < 5) return regs_r + f;
    if (op < 9) return (f << 26) + regs_i;
    return (f << 26) + 32'(tgt);
  endfunction

  function automatic bit exp_rdy();
    return m_live && !m_pend && (m_cnt < CAP) && !if0.clear;
  endfunction

  task automatic model_reset();
    m_live = 0; m_pend = 0; m_err = 0; m_acc = 0;
    m_cnt = 0; m_la0 = 0; m_la1 = 0; m_lw = 32'h0; m_csum = 32'h0;
  endtask

  // one clock edge worth of behaviour, evaluated with pre-edge state and current inputs
  task automatic model_update();
    bit acc;
    bit legal;
    acc   = if0.in_valid && exp_rdy();
    legal = (if0.op_sel <= 4'd9);
    if (if0.clear) begin
      m_cnt = 0; m_pend = 0; m_csum = 32'h0;
    end else if (m_pend) begin
      m_cnt++; m_pend = 0; m_csum = m_csum ^ m_lw;
    end
    if (acc && legal) begin
      m_pend = 1;
      m_lw   = ref_encode(if0.op_sel, if0.rs, if0.rt, if0.rd, if0.imm, if0.target);
      m_la0  = m_cnt % CAP;
      m_la1  = (B1 + m_cnt) % CAP;
    end
    m_err  = acc && !legal;
    m_acc  = acc;
    m_live = 1;
  endtask

  task automatic check_outs();
    chk("in_ready0", if0.in_ready, exp_rdy());
    chk("in_ready1", if1.in_ready, exp_rdy());
    chk("imem_we0", if0.imem_we, m_pend && !if0.clear);
    chk("imem_we1", if1.imem_we, m_pend && !if0.clear);
    chk("imem_addr0", if0.imem_addr, m_la0);
    chk("imem_addr1", if1.imem_addr, m_la1);
    chk("imem_wdata0", if0.imem_wdata, m_lw);
    chk("imem_wdata1", if1.imem_wdata, m_lw);
    chk("count0", if0.count, m_cnt);
    chk("count1", if1.count, m_cnt);
    chk("full0", if0.full, m_cnt == CAP);
    chk("err0", if0.err, m_err);
    chk("err1", if1.err, m_err);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    chk("checksum0", if0.checksum, m_csum);
    chk("checksum1", if1.checksum, m_csum);
`endif
  endtask

  // inputs were set at edge+1; check at edge+2, advance model on the edge, return at edge+1
  task automatic step();
    #1;
    check_outs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    if0.in_valid = 1'b1;
    if0.op_sel = op; if0.rs = rs; if0.rt = rt; if0.rd = rd; if0.imm = imm; if0.target = tgt;
  endtask

  // hold the request until accepted; returns in the cycle right after the accepting edge
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    bit done;
    done = 0;
    set_req(op, rs, rt, rd, imm, tgt);
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      done = m_acc;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL send_timeout: request op=%0d not accepted within 20 cycles", op);
    end
  endtask

  task automatic clear_cycle();
    if0.clear = 1'b1;
    step();
    if0.clear = 1'b0;
  endtask

  initial begin
    tbl[0] = '{4'd0, 5'd1,  5'd2, 5'd3, 16'h0000, 26'h0,    1'b0, 32'h00221820, 0};
    tbl[1] = '{4'd5, 5'd0,  5'd8, 5'd9, 16'h0005, 26'h0,    1'b1, 32'h20080005, 0};
    tbl[2] = '{4'd6, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0,    1'b0, 32'h8FA80004, 1};
    tbl[3] = '{4'd7, 5'd4,  5'd5, 5'd7, 16'hFFFC, 26'h0,    1'b0, 32'hAC85FFFC, 2};
    tbl[4] = '{4'd9, 5'd31, 5'd9, 5'd4, 16'h1234, 26'h10,   1'b0, 32'h08000010, 3};
    tbl[5] = '{4'd1, 5'd1,  5'd2, 5'd3, 16'h0000, 26'h0,    1'b1, 32'h00221822, 0};
    tbl[6] = '{4'd2, 5'd1,  5'd2, 5'd3, 16'hFFFF, 26'h0,    1'b0, 32'h00221824, 1};
    tbl[7] = '{4'd3, 5'd1,  5'd2, 5'd3, 16'h0000, 26'h3FF,  1'b0, 32'h00221825, 2};
    tbl[8] = '{4'd4, 5'd1,  5'd2, 5'd3, 16'h0000, 26'h0,    1'b0, 32'h0022182A, 3};
    tbl[9] = '{4'd8, 5'd1,  5'd2, 5'd9, 16'h0003, 26'h0,    1'b1, 32'h10220003, 0};

    // reset: all outputs at their reset values, not ready
    rst = 1'b0;
    if0.in_valid = 1'b1; if0.op_sel = 4'd0; if0.rs = 5'd1; if0.rt = 5'd2; if0.rd = 5'd3;
    if0.imm = 16'h0; if0.target = 26'h0; if0.clear = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk); #2;
      check_outs();
    end
    rst = 1'b1;
    if0.in_valid = 1'b0;
    step();
    chk("ready_after_reset", if0.in_ready, 1'b1);

    // vector table: first entry is the first write after reset
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].clr_before) clear_cycle();
      send(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, tbl[i].tgt);
      #1;
      chk($sformatf("tbl%0d_wdata", i), if0.imem_wdata, tbl[i].word);
      chk($sformatf("tbl%0d_addr", i), if0.imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_addr_b3", i), if1.imem_addr, (tbl[i].addr + B1) % CAP);
      chk($sformatf("tbl%0d_we", i), if0.imem_we, 1'b1);
      chk($sformatf("tbl%0d_ready_in_write", i), if0.in_ready, 1'b0);
      if (i == 0) begin
        if0.in_valid = 1'b0;
        step();
        chk("first_count", if0.count, 1);
      end
    end
    if0.in_valid = 1'b0;
    step();

    // illegal op: one-cycle err, no write, count unchanged (1 after BEQ)
    send(4'd12, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    if0.in_valid = 1'b0;
    #1;
    chk("illegal_err", if0.err, 1'b1);
    chk("illegal_no_we", if0.imem_we, 1'b0);
    chk("illegal_count", if0.count, 1);
    step();
    chk("illegal_err_drop", if0.err, 1'b0);

    // clear during WRITE aborts the write
    send(4'd0, 5'd7, 5'd7, 5'd7, 16'h0, 26'h0);
    if0.in_valid = 1'b0;
    #1;
    chk("abort_we_before", if0.imem_we, 1'b1);
    if0.clear = 1'b1;
    #1;
    chk("abort_we_dropped", if0.imem_we, 1'b0);
    step();
    if0.clear = 1'b0;
    #1;
    chk("abort_count", if0.count, 0);
    chk("abort_idle_ready", if0.in_ready, 1'b1);

    // fill to full, extra requests ignored, clear restarts at address 0 / BASE
    for (int i = 0; i < CAP; i++) send(4'd5, 5'(i), 5'(i + 1), 5'd0, 16'(i * 3), 26'h0);
    step();
    #1;
    chk("full_flag", if0.full, 1'b1);
    chk("full_flag_b3", if1.full, 1'b1);
    chk("full_not_ready", if0.in_ready, 1'b0);
    repeat (3) step();
    chk("full_count_held", if0.count, CAP);
    if0.in_valid = 1'b0;
    clear_cycle();
    send(4'd3, 5'd9, 5'd8, 5'd7, 16'h0, 26'h0);
    #1;
    chk("post_clear_addr", if0.imem_addr, 0);
    chk("post_clear_addr_b3", if1.imem_addr, B1);
    if0.in_valid = 1'b0;
    step();

`ifdef INSTR_ENCODER_CHECKSUM_EN
    clear_cycle();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(4'd5, 5'd0, 5'd8, 5'd0, 16'h5, 26'h0);
    if0.in_valid = 1'b0;
    step();
    chk("checksum_pair", if0.checksum, 32'h202A1825);
`endif

    // async reset in the middle of a write drops the strobe at once
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    if0.in_valid = 1'b0;
    #1;
    chk("rst_mid_we_before", if0.imem_we, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_mid_we0", if0.imem_we, 1'b0);
    chk("rst_mid_we1", if1.imem_we, 1'b0);
    chk("rst_mid_wdata", if0.imem_wdata, 32'h0);
    model_reset();
    @(posedge clk); #2;
    check_outs();
    rst = 1'b1;
    step();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if0.in_valid = ($urandom_range(0, 9) < 6);
      if0.op_sel   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      if0.rs       = 5'($urandom);
      if0.rt       = 5'($urandom);
      if0.rd       = 5'($urandom);
      if0.imm      = 16'($urandom);
      if0.target   = 26'($urandom);
      if0.clear    = ($urandom_range(0, 24) == 0);
      step();
    end
    if0.clear = 1'b0;
    if0.in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
